q_change_fifo: RTL and testbench
================================

Q_CHANGE_FIFO -- requirements
Module: q_change_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width of the monitored register output.
REQ-002 SHALL have parameter DEPTH, default 4: FIFO entries; a power of two, minimum 2.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-004 SHALL have port clk, input, 1 bit: rising-edge clock shared with the upstream 8-bit register.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port q_in, input, WIDTH bits: Q output of the upstream register.
REQ-007 SHALL have port en, input, 1 bit: sample enable; q_in is ignored when en=0.
REQ-008 SHALL have port out_data, output, WIDTH bits: FIFO head value.
REQ-009 SHALL have port out_valid, output, 1 bit: FIFO non-empty.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the head.
REQ-011 SHALL have ports full and empty, output, 1 bit each: FIFO status.
REQ-012 SHALL have port level, output, $clog2(DEPTH)+1 bits: current entry count, 0..DEPTH.
REQ-013 SHALL have port drop_cnt, output, 8 bits: count of change events lost because the FIFO was full.

Function
REQ-014 SHALL hold a prev register (WIDTH bits) and a primed flag.
REQ-015 SHALL load prev with q_in on every rising edge where en=1.
REQ-016 SHALL set primed on the first en=1 edge after reset, with no push on that edge.
REQ-017 SHALL raise a change event on an edge where en=1, primed=1 and q_in != prev.
REQ-018 SHALL push q_in (the new value) into the FIFO tail on a change event.
REQ-019 SHALL pop on any edge where out_valid=1 and out_ready=1.
REQ-020 SHALL be first-word fall-through: out_data = head entry combinationally; out_data is don't-care when empty.
REQ-021 SHALL have latency: a change sampled at edge N gives out_valid=1 with that value after edge N (cycle N+1), when the FIFO was empty.
REQ-022 SHALL, for push and pop on the same edge with the FIFO not empty, perform both; level is unchanged.
REQ-023 SHALL, for push and pop on the same edge with the FIFO full, accept the push; it is not dropped.
REQ-024 SHALL, for a push on a full FIFO with no pop, drop the value and increment drop_cnt.
REQ-025 SHALL saturate drop_cnt at 255; it SHALL never wrap.
REQ-026 SHALL leave storage and level unchanged on a dropped push.
REQ-027 SHALL ignore out_ready when the FIFO is empty; there is no pop and no underflow.
REQ-028 SHALL wrap read and write pointers modulo DEPTH.
REQ-029 SHALL derive full as (level == DEPTH) and empty as (level == 0).
REQ-030 SHALL make out_valid equal to !empty.
REQ-031 SHALL produce no event when en=0, even if q_in changes; the next en=1 edge compares against the last sampled prev.

Reset
REQ-032 SHALL, while rst_n=0, immediately and asynchronously clear: primed=0, prev=0, pointers=0, level=0, drop_cnt=0.
REQ-033 SHALL drive outputs during reset as: out_valid=0, empty=1, full=0, level=0, drop_cnt=0.
REQ-034 SHALL, on reset asserted mid-operation, discard queued entries; after release, the first en=1 edge only re-primes.
REQ-035 SHALL require no clock edge for reset to take effect, and SHALL treat rst_n release as synchronous to the clk rising edge.

Verification
REQ-036 Prime and single change: reset, en=1, q_in=0x05, then 0x06 -> no push on the 0x05 edge; out_valid=1 and out_data=0x06 the cycle after the 0x06 edge; level=1.
REQ-037 No change: q_in held at 0x33 for 10 cycles after priming -> out_valid stays 0 and level stays 0.
REQ-038 Fill and overflow: out_ready=0, q_in stepped 0x01..0x07 one per cycle after priming at 0x00 -> level=4, full=1, entries 0x01..0x04 held, drop_cnt=3.
REQ-039 Concurrent push/pop at full: FIFO full, out_ready=1 and a change to 0xAA on the same edge -> level stays 4, head advances, 0xAA is stored at the tail, drop_cnt unchanged.
REQ-040 Saturation and enable gating: 300 drops -> drop_cnt=255; en=0 while q_in toggles -> no pushes.
REQ-041 Async reset: rst_n pulsed low between clock edges with level=3 -> out_valid=0 and level=0 immediately; the next en=1 edge causes no push.

Source files
------------

// File: rtl/q_change_fifo.sv
// Change detector on an upstream register output: every new value seen on an
// enabled edge is queued in a first-word fall-through FIFO, with a drop counter.
module q_change_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           q_in,
  input  logic                       en,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic [7:0]                 drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] prev;
  logic             primed;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  logic change;
  logic pop;
  logic push;
  logic drop;

  assign full      = (level == LEVEL_FULL);
  assign empty     = (level == '0);
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr];

  // A full FIFO still takes a push when the head leaves on the same edge.
  assign change = en && primed && (q_in != prev);
  assign pop    = out_valid && out_ready;
  assign push   = change && (!full || pop);
  assign drop   = change && full && !pop;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev     <= '0;
      primed   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      drop_cnt <= '0;
    end else begin
      if (en) begin
        prev   <= q_in;
        primed <= 1'b1;
      end
      // Pointers are exactly AW bits wide, so DEPTH being a power of two gives the wrap.
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      level <= level + LEVEL_ONE;
      else if (pop && !push) level <= level - LEVEL_ONE;
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // NOTE: storage has no reset; an entry is only ever read after it was written,
  // so clearing it would just cost a reset net on every bit.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= q_in;
  end

endmodule

// File: tb/tb_q_change_fifo.sv
// Directed bench for q_change_fifo: a queue scoreboard tracks expected FIFO
// contents, pushed on modelled change events and popped on accepted heads.
module tb_q_change_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] q_in;
  logic             en;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             full;
  logic             empty;
  logic [2:0]       level;
  logic [7:0]       drop_cnt;

  q_change_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .q_in(q_in), .en(en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .full(full), .empty(empty), .level(level), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] sb[$];
  logic [WIDTH-1:0] m_prev;
  logic             m_primed;
  logic [7:0]       m_drop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    sb.delete();
    m_prev   = '0;
    m_primed = 1'b0;
    m_drop   = '0;
  endtask

  // One clock: predict the edge from current inputs, take the edge, then compare.
  task automatic cycle();
    logic m_pop;
    logic m_change;
    if (rst_n) begin
      m_pop = (sb.size() > 0) && out_ready;
      if (m_pop) begin
        check("head_at_pop", out_data, sb[0]);
        void'(sb.pop_front());
      end
      m_change = en && m_primed && (q_in != m_prev);
      if (m_change) begin
        if (sb.size() < DEPTH) sb.push_back(q_in);
        else if (m_drop != 8'hFF) m_drop++;
      end
      if (en) begin
        m_prev   = q_in;
        m_primed = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check("level",     level,     sb.size());
    check("out_valid", out_valid, sb.size() > 0);
    check("full",      full,      sb.size() == DEPTH);
    check("drop_cnt",  drop_cnt,  m_drop);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_clear();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_empty",     empty,     1'b1);
    check("rst_full",      full,      1'b0);
    check("rst_level",     level,     0);
    check("rst_drop_cnt",  drop_cnt,  0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; q_in = '0; out_ready = 1'b0;
    model_clear();
    #1;
    do_reset();

    // Prime on 0x05 with no push, then a single change to 0x06.
    en = 1'b1; q_in = 8'h05;
    cycle();
    check("prime_no_push", level, 0);
    q_in = 8'h06;
    cycle();
    check("single_valid", out_valid, 1'b1);
    check("single_data",  out_data,  8'h06);
    check("single_level", level,     1);
    en = 1'b0; out_ready = 1'b1;
    cycle();
    check("single_drained", empty, 1'b1);

    // Steady input produces nothing.
    do_reset();
    en = 1'b1; out_ready = 1'b0; q_in = 8'h33;
    for (int i = 0; i < 11; i++) cycle();
    check("steady_valid", out_valid, 1'b0);
    check("steady_level", level,     0);

    // Fill and overflow.
    do_reset();
    en = 1'b1; out_ready = 1'b0; q_in = 8'h00;
    cycle();
    for (int i = 1; i <= 7; i++) begin
      q_in = 8'(i);
      cycle();
    end
    check("fill_level", level,    4);
    check("fill_full",  full,     1'b1);
    check("fill_head",  out_data, 8'h01);
    check("fill_drops", drop_cnt, 3);

    // Push and pop together at full.
    out_ready = 1'b1; q_in = 8'hAA;
    cycle();
    check("pp_level", level,    4);
    check("pp_head",  out_data, 8'h02);
    check("pp_drops", drop_cnt, 3);
    en = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    check("pp_tail_aa", out_data, 8'hAA);
    cycle();
    check("pp_drained", empty, 1'b1);

    // Saturation: fill then 300 drops.
    en = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 304; i++) begin
      q_in = (i % 2 == 1) ? 8'h11 : 8'h22;
      cycle();
    end
    check("sat_drops", drop_cnt, 8'd255);
    check("sat_full",  full,     1'b1);

    // Enable gating: drain while q_in toggles with en low.
    en = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      q_in = 8'(8'h80 + i);
      cycle();
    end
    check("gate_level", level, 0);
    out_ready = 1'b0; en = 1'b1; q_in = 8'h11;
    cycle();
    check("gate_prev_kept", level, 0);
    check("gate_sat_kept",  drop_cnt, 8'd255);

    // Asynchronous reset with three entries queued.
    for (int i = 1; i <= 3; i++) begin
      q_in = 8'(i);
      cycle();
    end
    check("ar_level_before", level, 3);
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    check("ar_valid", out_valid, 1'b0);
    check("ar_level", level,     0);
    check("ar_drops", drop_cnt,  0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q_in = 8'h44;
    cycle();
    check("ar_reprime", level, 0);
    q_in = 8'h45;
    cycle();
    check("ar_after_level", level,    1);
    check("ar_after_data",  out_data, 8'h45);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
